dpram_copy_engine: RTL and testbench

- Initiator that drives both ports of the team's dual-port RAM to copy a block of words from a source region to a destination region (memmove semantics).
- Port 1 is used read-only. Port 2 is used write-only.
- Sits between a control/CPU-side register block (start/len/addresses) and the RAM instance. It pipelines one word per cycle, accounting for the RAM's registered-address read latency.

---
 rtl/dpram_copy_engine_if.sv | 40 ++++
 rtl/dpram_copy_engine.sv | 149 ++++++++++++++
 tb/tb_dpram_copy_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_copy_engine_if.sv
// Bundle of the copy engine's control-side and RAM-side signals.
// The master modport is the engine's view. The slave modport is the view
// of the register block and the RAM that surround it.
interface dpram_copy_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    // Control / register-block side
    logic                  Start;
    logic [ADDR_WIDTH-1:0] Src_Addr;
    logic [ADDR_WIDTH-1:0] Dst_Addr;
    logic [ADDR_WIDTH:0]   Length;
    logic                  Busy;
    logic                  Done;

    // RAM port 1 (read-only use)
    logic [ADDR_WIDTH-1:0] Ram_Address_1;
    logic                  Ram_WE_1;
    logic [DATA_WIDTH-1:0] Ram_Data_1;
    logic [DATA_WIDTH-1:0] Ram_Output_1;

    // RAM port 2 (write-only use)
    logic [ADDR_WIDTH-1:0] Ram_Address_2;
    logic                  Ram_WE_2;
    logic [DATA_WIDTH-1:0] Ram_Data_2;

    modport master (
        input  Start, Src_Addr, Dst_Addr, Length, Ram_Output_1,
        output Busy, Done,
        output Ram_Address_1, Ram_WE_1, Ram_Data_1,
        output Ram_Address_2, Ram_WE_2, Ram_Data_2
    );

    modport slave (
        output Start, Src_Addr, Dst_Addr, Length, Ram_Output_1,
        input  Busy, Done,
        input  Ram_Address_1, Ram_WE_1, Ram_Data_1,
        input  Ram_Address_2, Ram_WE_2, Ram_Data_2
    );
endinterface

// File: rtl/dpram_copy_engine.sv
// Block-copy engine for the dual-port RAM with memmove semantics.
// Port 1 reads one word per cycle, and port 2 writes the same word two
// cycles later. The copy direction is chosen so that a pending source word
// is never overwritten before it is read.
module dpram_copy_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                CLK,
    input  logic                RST,
    dpram_copy_engine_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   C_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  drain_q, drain_d;

    // Read stage: address on port 1 and the destination that goes with it
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] rd_dst_q, rd_dst_d;

    // Capture stage: Ram_Output_1 is valid while vld_p1 is set
    logic                  vld_p1_q, vld_p1_d;
    logic [ADDR_WIDTH-1:0] dst_p1_q, dst_p1_d;

    // Write stage: registered drive of port 2
    logic                  vld_p2_q, vld_p2_d;
    logic [ADDR_WIDTH-1:0] dst_p2_q, dst_p2_d;
    logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;

    logic                  start_dir;
    logic [ADDR_WIDTH-1:0] last_off;

    assign start_dir = (bus.Dst_Addr > bus.Src_Addr);
    assign last_off  = bus.Length[ADDR_WIDTH-1:0] - A_ONE;

    // Next-state logic: FSM sequencing plus the read/capture/write pipeline
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        drain_d   = drain_q;
        rd_addr_d = rd_addr_q;
        rd_dst_d  = rd_dst_q;
        vld_p1_d  = 1'b0;
        dst_p1_d  = rd_dst_q;
        vld_p2_d  = vld_p1_q;
        dst_p2_d  = dst_p1_q;
        data_p2_d = vld_p1_q ? bus.Ram_Output_1 : data_p2_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    if (bus.Length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        len_d   = bus.Length;
                        cnt_d   = '0;
                        dir_d   = start_dir;
                        // Backward copies start from the last word of each range
                        rd_addr_d = start_dir ? bus.Src_Addr + last_off : bus.Src_Addr;
                        rd_dst_d  = start_dir ? bus.Dst_Addr + last_off : bus.Dst_Addr;
                    end
                end
            end
            S_RUN: begin
                vld_p1_d = 1'b1;
                if (cnt_q == len_q - C_ONE) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + C_ONE;
                    rd_addr_d = dir_q ? rd_addr_q - A_ONE : rd_addr_q + A_ONE;
                    rd_dst_d  = dir_q ? rd_dst_q - A_ONE : rd_dst_q + A_ONE;
                end
            end
            S_DRAIN: begin
                // The last word needs one cycle to be captured and one to be written
                if (drain_q) begin
                    state_d = S_DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pipeline registers. Reset aborts any copy in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            drain_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_dst_q  <= '0;
            vld_p1_q  <= 1'b0;
            dst_p1_q  <= '0;
            vld_p2_q  <= 1'b0;
            dst_p2_q  <= '0;
            data_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            drain_q   <= drain_d;
            rd_addr_q <= rd_addr_d;
            rd_dst_q  <= rd_dst_d;
            vld_p1_q  <= vld_p1_d;
            dst_p1_q  <= dst_p1_d;
            vld_p2_q  <= vld_p2_d;
            dst_p2_q  <= dst_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    assign bus.Busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.Done          = (state_q == S_DONE);
    assign bus.Ram_Address_1 = rd_addr_q;
    assign bus.Ram_WE_1      = 1'b0;
    assign bus.Ram_Data_1    = '0;
    assign bus.Ram_Address_2 = dst_p2_q;
    assign bus.Ram_WE_2      = vld_p2_q;
    assign bus.Ram_Data_2    = data_p2_q;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Bench for dpram_copy_engine. It contains a behavioural dual-port RAM, a
// memmove reference model that feeds a write scoreboard, and directed and
// random copy scenarios.
module tb_dpram_copy_engine;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index. The value seen at a negedge is the number of the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    dpram_copy_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Behavioural RAM: registered read address on port 1, write on port 2
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] img [DEPTH];
    logic          load_img;
    logic [DW-1:0] rd_q;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (bus.Ram_WE_2) begin
            mem[bus.Ram_Address_2] <= bus.Ram_Data_2;
        end
        rd_q <= mem[bus.Ram_Address_1];
    end

    assign bus.Ram_Output_1 = rd_q;

    logic [DW-1:0] ref_mem [DEPTH];
    wr_t           exp_q [$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic load_pattern(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       img[i] = DW'(i + 'h40);
                1:       img[i] = DW'(i);
                default: img[i] = DW'($urandom_range(0, 255));
            endcase
            ref_mem[i] = img[i];
        end
        @(negedge clk);
        load_img = 1'b1;
        @(negedge clk);
        load_img = 1'b0;
    endtask

    // memmove reference: the data always comes from the pre-copy snapshot.
    // Writes are queued in the order the direction rule dictates.
    task automatic model(input int src, input int dst, input int len, input int s, input int nwords);
        logic [DW-1:0] old [DEPTH];
        bit            back;
        int            j;
        int            a;
        for (int i = 0; i < DEPTH; i++) old[i] = ref_mem[i];
        back = (dst > src);
        for (int k = 0; k < nwords; k++) begin
            j = back ? (len - 1 - k) : k;
            a = (dst + j) % DEPTH;
            exp_q.push_back('{c: s + 3 + k, a: a, d: int'(old[(src + j) % DEPTH])});
            ref_mem[a] = old[(src + j) % DEPTH];
        end
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: RAM[%0d] got %0d, required %0d", name, bad, mem[bad], ref_mem[bad]);
        end
    endtask

    task automatic do_copy(input int src, input int dst, input int len, input bit poke);
        int s;
        int busy_n;
        int busy_first;
        int done_n;
        int done_at;
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Src_Addr = AW'(src);
        bus.Dst_Addr = AW'(dst);
        bus.Length   = (AW + 1)'(len);
        s = cyc;
        model(src, dst, len, s, len);
        busy_n = 0; busy_first = -1; done_n = 0; done_at = -1;
        for (int t = 1; t <= len + 8; t++) begin
            @(negedge clk);
            bus.Start = (poke && t == 2);
            if (poke && t == 2) begin
                bus.Src_Addr = AW'(1);
                bus.Dst_Addr = AW'(2);
                bus.Length   = (AW + 1)'(3);
            end
            if (bus.Busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc - s;
            end
            if (bus.Done) begin
                done_n++;
                if (done_at < 0) done_at = cyc - s;
            end
        end
        bus.Start = 1'b0;
        chk("busy_cycles", busy_n, (len == 0) ? 0 : len + 2);
        if (len > 0) chk("busy_first", busy_first, 1);
        chk("done_count", done_n, 1);
        chk("done_cycle", done_at, (len == 0) ? 1 : len + 3);
        chk("writes_pending", exp_q.size(), 0);
        mem_compare("mem_image");
    endtask

    task automatic reset_midcopy();
        int s;
        int done_n;
        load_pattern(0);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Src_Addr = AW'(0);
        bus.Dst_Addr = AW'(32);
        bus.Length   = (AW + 1)'(8);
        s = cyc;
        model(0, 32, 8, s, 2);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        // In cycle s+4 (second write). The edge that would start the third write cycle sees RST.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_we2", bus.Ram_WE_2, 0);
        chk("rst_addr2", bus.Ram_Address_2, 0);
        chk("rst_data2", bus.Ram_Data_2, 0);
        rst = 1'b0;
        done_n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.Done) done_n++;
        end
        chk("rst_no_done", done_n, 0);
        chk("rst_writes_pending", exp_q.size(), 0);
        mem_compare("rst_mem_image");
    endtask

    initial begin
        int len;
        int src;
        int dst;
        rst          = 1'b1;
        load_img     = 1'b0;
        bus.Start    = 1'b0;
        bus.Src_Addr = '0;
        bus.Dst_Addr = '0;
        bus.Length   = '0;

        // Scoreboard monitor: every port-2 write is matched against the queue
        fork
            forever begin
                wr_t e;
                @(negedge clk);
                if (bus.Ram_WE_2 === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, required no write",
                                 bus.Ram_Address_2, bus.Ram_Data_2, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_cycle", cyc, e.c);
                        chk("wr_addr", bus.Ram_Address_2, e.a);
                        chk("wr_data", bus.Ram_Data_2, e.d);
                        chk("we1_low", bus.Ram_WE_1, 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy", bus.Busy, 0);
        chk("reset_done", bus.Done, 0);
        chk("reset_we2", bus.Ram_WE_2, 0);
        chk("reset_addr1", bus.Ram_Address_1, 0);
        chk("reset_addr2", bus.Ram_Address_2, 0);
        chk("reset_data2", bus.Ram_Data_2, 0);
        chk("reset_we1", bus.Ram_WE_1, 0);
        chk("reset_data1", bus.Ram_Data_1, 0);
        rst = 1'b0;

        // Basic backward copy, with a second Start during Busy that must be ignored
        load_pattern(0);
        do_copy(0, 32, 4, 1'b1);

        // Overlapping forward and backward copies
        load_pattern(1);
        do_copy(10, 8, 6, 1'b0);
        load_pattern(1);
        do_copy(8, 10, 6, 1'b0);

        // Source wraps past the top address
        load_pattern(1);
        do_copy(62, 5, 4, 1'b0);

        // Whole array onto itself
        load_pattern(2);
        do_copy(0, 0, 64, 1'b0);

        // Zero length
        load_pattern(2);
        do_copy(3, 9, 0, 1'b0);

        // Reset in the middle of a copy, then a normal copy
        reset_midcopy();
        load_pattern(2);
        do_copy(20, 40, 5, 1'b0);

        // Random non-wrapping copies
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, DEPTH);
            src = $urandom_range(0, DEPTH - len);
            dst = $urandom_range(0, DEPTH - len);
            load_pattern(2);
            do_copy(src, dst, len, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
